encrypt_sequencer: RTL and testbench

- Hardware sequencer that runs the Program #1 LFSR encryption directly against data memory, without using the instruction stream.
- Reads its config bytes at DM[61..63] and the plaintext at DM[0..51], then writes 64 parity-tagged ciphertext bytes to DM[64..127].
- Uses the same Start/Ack launch protocol as TopLevel, so the existing encryption bench can drive it.
- Owns the single DM port while Busy=1; the top level muxes the DM port on Busy.

---
 rtl/enc_seq_pkg.sv | 23 ++
 rtl/encrypt_sequencer_lfsr7.sv | 28 ++
 rtl/encrypt_sequencer.sv | 160 ++++++++++++++++
 tb/tb_encrypt_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/enc_seq_pkg.sv
// Shared types and constants for the data-memory LFSR encryption sequencer.
package enc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG0,
        CFG1,
        CFG2,
        CFG3,
        ENC_RD,
        ENC_WR,
        DONE
    } state_t;

    localparam logic [7:0]  PAD_CHAR     = 8'h20;
    localparam int unsigned LFSR_W       = 7;

    // Offsets of the config bytes relative to CFG_BASE
    localparam int unsigned CFG_PRE_OFS  = 0;
    localparam int unsigned CFG_PTRN_OFS = 1;
    localparam int unsigned CFG_INIT_OFS = 2;

endpackage

// File: rtl/encrypt_sequencer_lfsr7.sv
// 7-bit Fibonacci-style LFSR: shifts left, feedback is the parity of state & taps.
module lfsr7
    import enc_seq_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_init,
    input  logic              i_step,
    input  logic [LFSR_W-1:0] i_ptrn,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= i_init;
        end else if (i_step) begin
            r_state <= {r_state[LFSR_W-2:0], ^(r_state & i_ptrn)};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/encrypt_sequencer.sv
// Runs the LFSR encryption straight out of data memory: config at CFG_BASE,
// plaintext at 0.., parity-tagged ciphertext written to OUT_BASE..
module encrypt_sequencer
    import enc_seq_pkg::*;
#(
    parameter int unsigned MSG_MAX  = 52,
    parameter int unsigned N_OUT    = 64,
    parameter int unsigned OUT_BASE = 64,
    parameter int unsigned CFG_BASE = 61,
    parameter int unsigned AW       = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    output logic          Ack,
    output logic          Busy,
    output logic [AW-1:0] MemAddr,
    output logic          MemWrEn,
    output logic [7:0]    MemWrData,
    input  logic [7:0]    MemRdData
);

    localparam logic [7:0] MSG_MAX_B = 8'(MSG_MAX);
    localparam logic [6:0] LAST_I    = 7'(N_OUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_start_q;
    logic              r_ack;
    logic [7:0]        r_pre;
    logic [LFSR_W-1:0] r_ptrn;
    logic [6:0]        r_i;
    logic              r_from_rd;

    logic              w_launch;
    logic [6:0]        w_i_pos;
    logic [8:0]        w_k;
    logic              w_rd_pos;
    logic [7:0]        w_ch;
    logic [LFSR_W-1:0] w_c;
    logic [LFSR_W-1:0] w_init;
    logic [LFSR_W-1:0] w_lfsr;

    assign w_launch = r_start_q && !Start && (r_state == IDLE || r_state == DONE);

    // Position whose read/pad decision is being made this cycle: the upcoming one
    // when leaving CFG3 or ENC_WR, otherwise the current one (ENC_RD).
    always_comb begin
        w_i_pos = r_i;
        if (r_state == CFG3)
            w_i_pos = '0;
        else if (r_state == ENC_WR)
            w_i_pos = r_i + 7'd1;
    end

    assign w_k      = {2'b00, w_i_pos} - {1'b0, r_pre};
    assign w_rd_pos = !w_k[8] && (w_k[7:0] < MSG_MAX_B);

    assign w_ch = r_from_rd ? MemRdData : PAD_CHAR;
    // Low 7 bits of the 8-bit subtraction equal the 7-bit subtraction
    assign w_c  = (w_ch[LFSR_W-1:0] - PAD_CHAR[LFSR_W-1:0]) ^ w_lfsr;

    assign w_init = (MemRdData[LFSR_W-1:0] == '0) ? 7'h01 : MemRdData[LFSR_W-1:0];

    lfsr7 u_lfsr (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_load  (r_state == CFG3),
        .i_init  (w_init),
        .i_step  (r_state == ENC_WR),
        .i_ptrn  (r_ptrn),
        .o_state (w_lfsr)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_launch) w_next = CFG0;
            CFG0:    w_next = CFG1;
            CFG1:    w_next = CFG2;
            CFG2:    w_next = CFG3;
            CFG3:    w_next = w_rd_pos ? ENC_RD : ENC_WR;
            ENC_RD:  w_next = ENC_WR;
            ENC_WR: begin
                if (r_i == LAST_I)
                    w_next = DONE;
                else
                    w_next = w_rd_pos ? ENC_RD : ENC_WR;
            end
            DONE:    if (w_launch) w_next = CFG0;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        Busy      = 1'b0;
        MemAddr   = '0;
        MemWrEn   = 1'b0;
        MemWrData = '0;
        case (r_state)
            CFG0: begin
                Busy    = 1'b1;
                MemAddr = AW'(CFG_BASE + CFG_PRE_OFS);
            end
            CFG1: begin
                Busy    = 1'b1;
                MemAddr = AW'(CFG_BASE + CFG_PTRN_OFS);
            end
            CFG2: begin
                Busy    = 1'b1;
                MemAddr = AW'(CFG_BASE + CFG_INIT_OFS);
            end
            CFG3:   Busy = 1'b1;
            ENC_RD: begin
                Busy    = 1'b1;
                MemAddr = AW'(w_k[7:0]);
            end
            ENC_WR: begin
                Busy      = 1'b1;
                MemAddr   = AW'(OUT_BASE) + AW'(r_i);
                MemWrEn   = 1'b1;
                MemWrData = {^w_c, w_c};
            end
            default: ;
        endcase
    end

    assign Ack = r_ack;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_start_q <= 1'b1;
            r_ack     <= 1'b0;
            r_pre     <= '0;
            r_ptrn    <= '0;
            r_i       <= '0;
            r_from_rd <= 1'b0;
        end else begin
            r_start_q <= Start;
            r_ack     <= (r_state == DONE) && !w_launch;
            r_from_rd <= (r_state == ENC_RD);
            if (r_state == CFG1)
                r_pre <= MemRdData;
            if (r_state == CFG2)
                r_ptrn <= MemRdData[LFSR_W-1:0];
            if (r_state == CFG3)
                r_i <= '0;
            else if (r_state == ENC_WR)
                r_i <= r_i + 7'd1;
        end
    end

endmodule

// File: tb/tb_encrypt_sequencer.sv
// Bench for encrypt_sequencer: behavioural DM with registered read, randomized
// runs compared against a plain-arithmetic encryption model.
module tb_encrypt_sequencer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b1;
    logic       Ack;
    logic       Busy;
    logic [7:0] MemAddr;
    logic       MemWrEn;
    logic [7:0] MemWrData;
    logic [7:0] MemRdData;

    logic [7:0] mem [256];
    logic [7:0] exp_ct [64];
    int         exp_reads;
    int         n_checks = 0;
    int         n_pass = 0;
    int         wr_count = 0;
    int         low_wr = 0;
    int         addr_low = 0;

    encrypt_sequencer #(
        .MSG_MAX  (52),
        .N_OUT    (64),
        .OUT_BASE (64),
        .CFG_BASE (61),
        .AW       (8)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Ack       (Ack),
        .Busy      (Busy),
        .MemAddr   (MemAddr),
        .MemWrEn   (MemWrEn),
        .MemWrData (MemWrData),
        .MemRdData (MemRdData)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (MemWrEn === 1'b1) begin
            mem[MemAddr] <= MemWrData;
            wr_count     <= wr_count + 1;
            if (MemAddr < 8'd64)
                low_wr <= low_wr + 1;
        end
        MemRdData <= mem[MemAddr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic fill_plain();
        for (int i = 0; i < 52; i++) mem[i] = 8'($urandom);
        for (int i = 64; i < 128; i++) mem[i] = 8'h00;
    endtask

    task automatic set_cfg(input logic [7:0] pre, input logic [7:0] ptrn, input logic [7:0] init);
        mem[61] = pre;
        mem[62] = ptrn;
        mem[63] = init;
    endtask

    // Expected ciphertext from the config and plaintext currently in memory
    function automatic void build_model();
        int         k;
        int         pre;
        logic [6:0] taps;
        logic [6:0] l;
        logic [6:0] c;
        logic [7:0] ch;
        pre  = int'(mem[61]);
        taps = mem[62][6:0];
        l    = (mem[63][6:0] == 7'd0) ? 7'h01 : mem[63][6:0];
        exp_reads = 0;
        for (int i = 0; i < 64; i++) begin
            k = i - pre;
            if (k >= 0 && k < 52) begin
                ch = mem[k];
                exp_reads++;
            end else begin
                ch = 8'h20;
            end
            c = 7'(ch - 8'h20) ^ l;
            exp_ct[i] = {^c, c};
            l = {l[5:0], ^(l & taps)};
        end
    endfunction

    // Launch a run; n = rising edges after the launch-sampling edge until Ack is seen
    task automatic run(input int pulse_at, output int n);
        @(negedge Clk) Start = 1'b1;
        @(negedge Clk) Start = 1'b0;
        @(posedge Clk);
        #1;
        n = 0;
        addr_low = 0;
        while (Ack !== 1'b1 && n < 400) begin
            @(posedge Clk);
            #1;
            n++;
            if (Busy && n >= 4 && MemAddr < 8'd64) addr_low++;
            if (n == pulse_at) Start = 1'b1;
            if (n == pulse_at + 1) Start = 1'b0;
        end
    endtask

    task automatic verify(input string tag);
        for (int i = 0; i < 64; i++)
            check($sformatf("%s ct[%0d]", tag, i), {24'd0, mem[64 + i]}, {24'd0, exp_ct[i]});
    endtask

    initial begin
        int n;
        int busy_seen;
        int found;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        repeat (3) @(posedge Clk);
        #1;
        check("reset Ack", {31'd0, Ack}, 32'd0);
        check("reset Busy", {31'd0, Busy}, 32'd0);
        check("reset MemWrEn", {31'd0, MemWrEn}, 32'd0);
        check("reset MemAddr", {24'd0, MemAddr}, 32'd0);
        check("reset MemWrData", {24'd0, MemWrData}, 32'd0);

        @(negedge Clk) Reset = 1'b1;
        busy_seen = 0;
        wr_count  = 0;
        repeat (50) @(negedge Clk) if (Busy !== 1'b0) busy_seen++;
        check("start-held busy cycles", busy_seen, 0);
        check("start-held writes", wr_count, 0);
        check("start-held Ack", {31'd0, Ack}, 32'd0);

        fill_plain();
        mem[0] = 8'h41;
        set_cfg(8'd10, 8'h7B, 8'h01);
        build_model();
        run(-10, n);
        check("pre10 cycles", n, 121);
        check("pre10 DM[64]", {24'd0, mem[64]}, 32'h81);
        check("pre10 DM[65]", {24'd0, mem[65]}, 32'h03);
        check("pre10 DM[66]", {24'd0, mem[66]}, 32'h06);
        check("pre10 DM[74]", {24'd0, mem[74]}, 32'h1B);
        verify("pre10");

        fill_plain();
        set_cfg(8'd10, 8'h7B, 8'h00);
        build_model();
        run(-10, n);
        check("init0 DM[64]", {24'd0, mem[64]}, 32'h81);
        check("init0 cycles", n, 4 + 64 + exp_reads + 1);
        verify("init0");

        fill_plain();
        set_cfg(8'd64, 8'hC5, 8'h2A);
        build_model();
        low_wr = 0;
        run(-10, n);
        check("pre64 cycles", n, 69);
        check("pre64 low addr", addr_low, 0);
        check("pre64 low writes", low_wr, 0);
        verify("pre64");

        fill_plain();
        set_cfg(8'd10, 8'h7B, 8'h01);
        build_model();
        run(30, n);
        check("pulse cycles", n, 121);
        verify("pulse");

        fill_plain();
        set_cfg(8'd3, 8'h5D, 8'h13);
        build_model();
        @(negedge Clk) Start = 1'b1;
        @(negedge Clk) Start = 1'b0;
        n = 0;
        found = 0;
        while (found == 0 && n < 400) begin
            @(posedge Clk);
            #1;
            n++;
            if (MemWrEn === 1'b1 && MemAddr == 8'd84) found = 1;
        end
        check("reach pos20 write", found, 1);
        Reset = 1'b0;
        #1;
        check("async rst Ack", {31'd0, Ack}, 32'd0);
        check("async rst Busy", {31'd0, Busy}, 32'd0);
        check("async rst MemWrEn", {31'd0, MemWrEn}, 32'd0);
        Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk) Reset = 1'b1;
        for (int i = 64; i < 128; i++) mem[i] = 8'h00;
        run(-10, n);
        check("relaunch cycles", n, 4 + 64 + exp_reads + 1);
        verify("relaunch");

        fill_plain();
        set_cfg(8'd0, 8'($urandom), 8'($urandom));
        build_model();
        run(-10, n);
        check("pre0 cycles", n, 4 + 64 + 52 + 1);
        verify("pre0");

        for (int r = 0; r < 6; r++) begin
            fill_plain();
            set_cfg(8'($urandom_range(0, 80)), 8'($urandom),
                    (r == 2) ? 8'h80 : 8'($urandom));
            build_model();
            low_wr = 0;
            run((r % 2 == 0) ? int'($urandom_range(5, 60)) : -10, n);
            check($sformatf("rand%0d cycles", r), n, 4 + 64 + exp_reads + 1);
            check($sformatf("rand%0d low writes", r), low_wr, 0);
            verify($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
